// File: rtl/fcmp_pkg.sv
// Shared definitions for the binary32 compare datapath: operation codes,
// field widths and classification helpers used by the core and its users.
package fcmp_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int FP_W  = 1 + EXP_W + MAN_W;

   typedef enum logic [1:0] {
      FCMP_EQ  = 2'b00,
      FCMP_LT  = 2'b01,
      FCMP_LE  = 2'b10,
      FCMP_RSV = 2'b11
   } fcmp_op_e;

   typedef struct packed {
      logic y;
      logic nv;
   } fcmp_res_t;

   function automatic logic is_nan(input logic [FP_W-1:0] x);
      return (x[FP_W-2 -: EXP_W] == {EXP_W{1'b1}}) && (x[MAN_W-1:0] != '0);
   endfunction

   function automatic logic is_snan(input logic [FP_W-1:0] x);
      return is_nan(x) && !x[MAN_W-1];
   endfunction

   function automatic logic is_zero(input logic [FP_W-1:0] x);
      return x[FP_W-2:0] == '0;
   endfunction

   // Maps sign-magnitude encodings onto an unsigned key whose natural order
   // matches numeric order for every non-NaN value except the two zeros.
   function automatic logic [FP_W-1:0] order_key(input logic [FP_W-1:0] x);
      return x[FP_W-1] ? ~x : {1'b1, x[FP_W-2:0]};
   endfunction

endpackage

// File: rtl/fcmp_core.sv
// Combinational binary32 feq/flt/fle evaluator with invalid-operation flag.
// Subnormals compare by exact value; +0 and -0 are equal.
module fcmp_core
   import fcmp_pkg::*;
(
   input  fcmp_op_e         op,
   input  logic [FP_W-1:0]  x1,
   input  logic [FP_W-1:0]  x2,
   output logic             y,
   output logic             nv
);

   logic            any_nan;
   logic            any_snan;
   logic            both_zero;
   logic            eq;
   logic            lt;
   logic [FP_W-1:0] key1;
   logic [FP_W-1:0] key2;

   assign any_nan   = is_nan(x1)  | is_nan(x2);
   assign any_snan  = is_snan(x1) | is_snan(x2);
   assign both_zero = is_zero(x1) & is_zero(x2);
   assign key1      = order_key(x1);
   assign key2      = order_key(x2);

   // Zeros of opposite sign would otherwise order -0 below +0.
   assign eq = (x1 == x2) | both_zero;
   assign lt = !both_zero && (key1 < key2);

   always_comb begin
      y  = 1'b0;
      nv = 1'b0;
      case (op)
         FCMP_EQ: begin
            y  = !any_nan && eq;
            nv = any_snan;
         end
         FCMP_LT: begin
            y  = !any_nan && lt;
            nv = any_nan;
         end
         FCMP_LE: begin
            y  = !any_nan && (lt | eq);
            nv = any_nan;
         end
         default: begin
            y  = 1'b0;
            nv = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/fcmp_arbiter.sv
// Two-requester round-robin front end sharing one fcmp_core through an
// operand stage (S1) and a result stage (S2) with full-throughput backpressure.
module fcmp_arbiter
   import fcmp_pkg::*;
#(
   parameter int TAG_W = 4
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [31:0]      req0_x1,
   input  logic [31:0]      req0_x2,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [31:0]      req1_x1,
   input  logic [31:0]      req1_x2,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [TAG_W-1:0] resp_tag,
   output logic             resp_y,
   output logic             resp_nv,
   output logic             busy
);

   localparam int NREQ = 2;

   logic [NREQ-1:0]  rq_valid;
   logic [NREQ-1:0]  rq_ready;
   logic [1:0]       rq_op  [NREQ];
   logic [FP_W-1:0]  rq_x1  [NREQ];
   logic [FP_W-1:0]  rq_x2  [NREQ];
   logic [TAG_W-1:0] rq_tag [NREQ];

   assign rq_valid  = {req1_valid, req0_valid};
   assign rq_op[0]  = req0_op;
   assign rq_op[1]  = req1_op;
   assign rq_x1[0]  = req0_x1;
   assign rq_x1[1]  = req1_x1;
   assign rq_x2[0]  = req0_x2;
   assign rq_x2[1]  = req1_x2;
   assign rq_tag[0] = req0_tag;
   assign rq_tag[1] = req1_tag;
   assign req0_ready = rq_ready[0];
   assign req1_ready = rq_ready[1];

   logic             rr_ptr_reg;
   logic             rr_ptr_next;
   logic             grant;
   logic             grant_valid;
   logic             adv1;
   logic             adv2;
   logic             accept;

   logic             s1_valid_reg;
   logic             s1_id_reg;
   fcmp_op_e         s1_op_reg;
   logic [FP_W-1:0]  s1_x1_reg;
   logic [FP_W-1:0]  s1_x2_reg;
   logic [TAG_W-1:0] s1_tag_reg;

   fcmp_op_e         s1_op_next;
   logic [FP_W-1:0]  s1_x1_next;
   logic [FP_W-1:0]  s1_x2_next;
   logic [TAG_W-1:0] s1_tag_next;

   logic             s2_valid_reg;
   logic             s2_id_reg;
   logic [TAG_W-1:0] s2_tag_reg;
   fcmp_res_t        s2_res_reg;
   fcmp_res_t        core_res;

   // Pipeline advance: S2 frees when empty or drained; S1 frees when S2 moves.
   assign adv2   = !s2_valid_reg | resp_ready;
   assign adv1   = !s1_valid_reg | adv2;
   assign accept = adv1 & grant_valid;

   always_comb begin
      grant_valid = |rq_valid;
      if (&rq_valid) begin
         grant = rr_ptr_reg;
      end else begin
         grant = rq_valid[1];
      end
   end

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
         assign rq_ready[gi] = adv1 & rq_valid[gi] & (grant == 1'(gi));
      end
   endgenerate

   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (accept) begin
         rr_ptr_next = ~grant;
      end
   end

   always_comb begin
      s1_op_next  = fcmp_op_e'(rq_op[grant]);
      s1_x1_next  = rq_x1[grant];
      s1_x2_next  = rq_x2[grant];
      s1_tag_next = rq_tag[grant];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_reg <= 1'b0;
      end else begin
         rr_ptr_reg <= rr_ptr_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         s1_id_reg    <= 1'b0;
         s1_op_reg    <= FCMP_EQ;
         s1_x1_reg    <= '0;
         s1_x2_reg    <= '0;
         s1_tag_reg   <= '0;
      end else if (adv1) begin
         s1_valid_reg <= accept;
         if (accept) begin
            s1_id_reg  <= grant;
            s1_op_reg  <= s1_op_next;
            s1_x1_reg  <= s1_x1_next;
            s1_x2_reg  <= s1_x2_next;
            s1_tag_reg <= s1_tag_next;
         end
      end
   end

   fcmp_core u_core (
      .op (s1_op_reg),
      .x1 (s1_x1_reg),
      .x2 (s1_x2_reg),
      .y  (core_res.y),
      .nv (core_res.nv)
   );

   // Result payload only reloads with a real entry, so it holds while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_reg <= 1'b0;
         s2_id_reg    <= 1'b0;
         s2_tag_reg   <= '0;
         s2_res_reg   <= '0;
      end else if (adv2) begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            s2_id_reg  <= s1_id_reg;
            s2_tag_reg <= s1_tag_reg;
            s2_res_reg <= core_res;
         end
      end
   end

   assign resp_valid = s2_valid_reg;
   assign resp_id    = s2_id_reg;
   assign resp_tag   = s2_tag_reg;
   assign resp_y     = s2_res_reg.y;
   assign resp_nv    = s2_res_reg.nv;
   assign busy       = s1_valid_reg | s2_valid_reg;

endmodule

// File: tb/tb_fcmp_arbiter.sv
// Scoreboard bench for fcmp_arbiter: drivers issue requests, a monitor checks
// arbitration, latency, stall stability and results against a real-valued model.
module tb_fcmp_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  v = 2'b00;
   logic [1:0]  op_d  [2];
   logic [31:0] a_d   [2];
   logic [31:0] b_d   [2];
   logic [3:0]  tag_d [2];
   logic        resp_ready = 1'b1;

   logic        req0_ready, req1_ready;
   logic        resp_valid, resp_id, resp_y, resp_nv, busy;
   logic [3:0]  resp_tag;

   always #5 clk = ~clk;

   fcmp_arbiter #(.TAG_W(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(v[0]), .req0_ready(req0_ready), .req0_op(op_d[0]),
      .req0_x1(a_d[0]), .req0_x2(b_d[0]), .req0_tag(tag_d[0]),
      .req1_valid(v[1]), .req1_ready(req1_ready), .req1_op(op_d[1]),
      .req1_x1(a_d[1]), .req1_x2(b_d[1]), .req1_tag(tag_d[1]),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_tag(resp_tag), .resp_y(resp_y), .resp_nv(resp_nv), .busy(busy)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int total_acc = 0;
   logic [1:0] took = 2'b00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic real f2r(input logic [31:0] x);
      int  e = int'(x[30:23]);
      int  mi;
      real s = x[31] ? -1.0 : 1.0;
      if (e == 255) return s * 1.0e300;
      if (e == 0) begin
         mi = int'(x[22:0]);
         e  = 1;
      end else begin
         mi = int'({1'b1, x[22:0]});
      end
      return s * $itor(mi) * (2.0 ** (e - 150));
   endfunction

   function automatic logic [1:0] ref_cmp(input logic [1:0] op, input logic [31:0] x1,
                                          input logic [31:0] x2);
      logic n1 = (x1[30:23] == 8'hFF) && (x1[22:0] != 0);
      logic n2 = (x2[30:23] == 8'hFF) && (x2[22:0] != 0);
      logic s1 = n1 && !x1[22];
      logic s2 = n2 && !x2[22];
      real  r1 = f2r(x1);
      real  r2 = f2r(x2);
      case (op)
         2'b00:   return {!(n1 | n2) && (r1 == r2), s1 | s2};
         2'b01:   return {!(n1 | n2) && (r1 <  r2), n1 | n2};
         2'b10:   return {!(n1 | n2) && (r1 <= r2), n1 | n2};
         default: return 2'b00;
      endcase
   endfunction

   // ---------------- scoreboard monitor ----------------
   typedef struct {
      logic       id;
      logic [3:0] tag;
      logic       y;
      logic       nv;
      int         cyc;
   } exp_t;

   exp_t q[$];

   initial begin
      logic       rr_m = 1'b0;
      logic       prev_stall = 1'b0;
      logic       eg, any_ok, ev;
      logic [1:0] rd;
      logic [1:0] r;
      logic       h_id, h_y, h_nv;
      logic [3:0] h_tag;
      exp_t       e;
      forever begin
         @(negedge clk);
         #4;
         cyc++;
         took = 2'b00;
         if (rst) begin
            q.delete();
            rr_m = 1'b0;
            prev_stall = 1'b0;
         end else begin
            rd = {req1_ready, req0_ready};
            any_ok = (q.size() < 2) || resp_ready;
            eg = (v == 2'b11) ? rr_m : v[1];
            chk("ready0", {31'd0, rd[0]}, {31'd0, any_ok && v[0] && !eg});
            chk("ready1", {31'd0, rd[1]}, {31'd0, any_ok && v[1] && eg});
            ev = (q.size() > 0) && (cyc - q[0].cyc >= 2);
            chk("resp_valid", {31'd0, resp_valid}, {31'd0, ev});
            chk("busy", {31'd0, busy}, {31'd0, q.size() > 0});
            if (prev_stall) begin
               chk("stall_valid", {31'd0, resp_valid}, 32'd1);
               chk("stall_hold", {28'd0, resp_id, resp_tag, resp_y, resp_nv},
                   {28'd0, h_id, h_tag, h_y, h_nv});
            end
            if (resp_valid && resp_ready) begin
               if (q.size() == 0) begin
                  chk("unexpected_resp", {28'd0, resp_id, resp_tag}, 32'hFFFF_FFFF);
               end else begin
                  e = q.pop_front();
                  chk("resp_id_tag", {27'd0, resp_id, resp_tag}, {27'd0, e.id, e.tag});
                  chk("resp_y_nv", {30'd0, resp_y, resp_nv}, {30'd0, e.y, e.nv});
               end
            end
            for (int n = 0; n < 2; n++) begin
               if (v[n] && rd[n]) begin
                  r = ref_cmp(op_d[n], a_d[n], b_d[n]);
                  e.id = n[0]; e.tag = tag_d[n]; e.y = r[1]; e.nv = r[0]; e.cyc = cyc;
                  q.push_back(e);
                  took[n] = 1'b1;
                  rr_m = ~n[0];
                  total_acc++;
               end
            end
            prev_stall = resp_valid && !resp_ready;
            h_id = resp_id; h_tag = resp_tag; h_y = resp_y; h_nv = resp_nv;
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [31:0] rnd_fp();
      logic [31:0] r = $urandom();
      case ($urandom_range(0, 7))
         0, 1: begin
            case ($urandom_range(0, 11))
               0: return 32'h0000_0000;
               1: return 32'h8000_0000;
               2: return 32'h0000_0001;
               3: return 32'h807F_FFFF;
               4: return 32'h0080_0000;
               5: return 32'h3F80_0000;
               6: return 32'hBF80_0000;
               7: return 32'h7F80_0000;
               8: return 32'hFF80_0000;
               9: return 32'h7FC0_0000;
               10: return 32'h7F80_0001;
               default: return 32'h7F7F_FFFF;
            endcase
         end
         2: return {r[31], 8'd0, r[22:0]};
         3: return {r[31], 8'd126 + {6'd0, r[24:23]}, r[22:0]};
         4: return {r[31], 8'hFF, r[22:1], 1'b1};
         default: return r;
      endcase
   endfunction

   task automatic new_req(input int n, input logic [3:0] t);
      v[n]     = 1'b1;
      op_d[n]  = 2'($urandom_range(0, 3));
      a_d[n]   = rnd_fp();
      b_d[n]   = ($urandom_range(0, 3) == 0) ? a_d[n] : rnd_fp();
      tag_d[n] = t;
   endtask

   task automatic drain();
      v = 2'b00;
      resp_ready = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   localparam int ND = 12;
   logic [1:0]  dop [ND] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd2,
                             2'd3, 2'd1, 2'd2, 2'd1};
   logic [31:0] dx1 [ND] = '{32'h3F800000, 32'hBF800000, 32'h80000000, 32'h7FC00000,
                             32'h7F800001, 32'h7FC00000, 32'h00000001, 32'h807FFFFF,
                             32'h3F800000, 32'hFF800000, 32'h00000000, 32'h00000000};
   logic [31:0] dx2 [ND] = '{32'h3F800000, 32'h00000000, 32'h00000000, 32'h7FC00000,
                             32'h3F800000, 32'h00000000, 32'h00000002, 32'h00000000,
                             32'h3F800000, 32'h7F800000, 32'h80000000, 32'h80000000};

   initial begin
      int idx, guard, acc0;
      logic [3:0] sent [2];
      logic [3:0] tagc [2];
      op_d = '{2'd0, 2'd0}; a_d = '{32'd0, 32'd0}; b_d = '{32'd0, 32'd0};
      tag_d = '{4'd0, 4'd0}; tagc = '{4'd0, 4'd0};
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_state", {28'd0, resp_valid, resp_y, resp_nv, busy}, 32'd0);
      chk("reset_id_tag", {27'd0, resp_id, resp_tag}, 32'd0);

      // fairness: both valid continuously, tags 0..3 each
      new_req(0, 4'd0); new_req(1, 4'd0);
      sent = '{4'd1, 4'd1};
      guard = 0;
      while (v != 2'b00 && guard < 40) begin
         @(negedge clk);
         guard++;
         for (int n = 0; n < 2; n++) begin
            if (took[n]) begin
               if (sent[n] < 4) begin
                  new_req(n, sent[n]);
                  sent[n]++;
               end else begin
                  v[n] = 1'b0;
               end
            end
         end
      end
      chk("fair_done", {31'd0, v == 2'b00}, 32'd1);
      drain();

      // directed single-requester back-to-back sequence
      v[0] = 1'b1; op_d[0] = dop[0]; a_d[0] = dx1[0]; b_d[0] = dx2[0]; tag_d[0] = 4'd0;
      idx = 1; guard = 0;
      while (idx <= ND && guard < 60) begin
         @(negedge clk);
         guard++;
         if (took[0]) begin
            if (idx < ND) begin
               op_d[0] = dop[idx]; a_d[0] = dx1[idx]; b_d[0] = dx2[idx]; tag_d[0] = 4'(idx);
            end else begin
               v[0] = 1'b0;
            end
            idx++;
         end
      end
      chk("dir_done", idx, ND + 1);
      drain();

      // backpressure with both requesters valid
      resp_ready = 1'b0;
      new_req(0, tagc[0]++); new_req(1, tagc[1]++);
      acc0 = total_acc;
      repeat (5) begin
         @(negedge clk);
         for (int n = 0; n < 2; n++) if (took[n]) new_req(n, tagc[n]++);
      end
      chk("bp_accepted", total_acc - acc0, 2);
      chk("bp_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
      resp_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         for (int n = 0; n < 2; n++) if (took[n]) new_req(n, tagc[n]++);
      end
      drain();

      // randomized traffic with random backpressure
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         for (int n = 0; n < 2; n++) begin
            if (!v[n] || took[n]) begin
               if ($urandom_range(0, 3) != 0) new_req(n, tagc[n]++);
               else v[n] = 1'b0;
            end
         end
         resp_ready = ($urandom_range(0, 3) != 0);
      end
      drain();

      // reset with two entries in flight
      resp_ready = 1'b0;
      new_req(0, tagc[0]++); new_req(1, tagc[1]++);
      repeat (3) begin
         @(negedge clk);
         for (int n = 0; n < 2; n++) if (took[n]) new_req(n, tagc[n]++);
      end
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      v = 2'b00;
      resp_ready = 1'b1;
      chk("post_rst_idle", {30'd0, resp_valid, busy}, 32'd0);
      @(negedge clk);
      new_req(0, 4'hA); new_req(1, 4'hB);
      @(negedge clk);
      chk("post_rst_rr", {30'd0, took}, 32'd1);
      v[0] = 1'b0;
      guard = 0;
      while (v != 2'b00 && guard < 10) begin
         @(negedge clk);
         guard++;
         if (took[1]) v[1] = 1'b0;
      end
      chk("post_rst_done", {31'd0, v == 2'b00}, 32'd1);
      repeat (8) @(negedge clk);
      chk("final_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
